// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: ping-pong controller for two 24-bit pixel frame buffers.
// The front buffer is scanned out in raster order. The back buffer takes
// random-access host writes. Front/back are exchanged only at frame
// boundaries, so the display never shows a torn frame.
module frame_buf_ctrl #(
  parameter int H_ACTIVE = 100,
  parameter int V_ACTIVE = 100,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_err,
  output logic              b0_re,
  output logic              b0_we,
  output logic [ADDR_W-1:0] b0_addr,
  output logic [31:0]       b0_wdata,
  input  logic [7:0]        b0_r,
  input  logic [7:0]        b0_g,
  input  logic [7:0]        b0_b,
  output logic              b1_re,
  output logic              b1_we,
  output logic [ADDR_W-1:0] b1_addr,
  output logic [31:0]       b1_wdata,
  input  logic [7:0]        b1_r,
  input  logic [7:0]        b1_g,
  input  logic [7:0]        b1_b,
  output logic              pix_valid,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              pix_sof,
  output logic              pix_eol
);

  localparam int                DEPTH     = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [15:0]       X_LAST    = 16'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCAN      = 2'd1,
    ST_FRAME_END = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic              front_sel_q, front_sel_d;
  logic              pending_q, pending_d;
  logic              swap_done_q, swap_done_d;
  logic              wr_ready_q, wr_ready_d;
  logic              wr_err_q, wr_err_d;
  logic              pix_valid_q, pix_valid_d;
  logic              pix_sel_q, pix_sel_d;
  logic [15:0]       pix_x_q, pix_x_d;
  logic [15:0]       pix_y_q, pix_y_d;
  logic              pix_sof_q, pix_sof_d;
  logic              pix_eol_q, pix_eol_d;

  logic rd_en_s;
  logic wr_acc_s;
  logic wr_in_s;
  logic wr_we_s;

  // Scan sequencer: next state and raster position of the next read issue.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_en) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_FRAME_END;
          addr_d  = ADDR_ZERO;
          x_d     = 16'd0;
          y_d     = 16'd0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
          if (x_q == X_LAST) begin
            x_d = 16'd0;
            y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
            y_d = y_q;
          end
        end
      end
      ST_FRAME_END: begin
        // scan_en is only sampled here, so a frame always runs to completion.
        if (scan_en) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = ADDR_ZERO;
        x_d     = 16'd0;
        y_d     = 16'd0;
      end
    endcase
  end

  // Swap bookkeeping: the toggle cycle is decided one cycle ahead so that
  // swap_done and the wr_ready stall are plain flops; front_sel flips at the
  // end of the toggle cycle, and a request landing in that cycle re-arms.
  always_comb begin
    pending_d   = (pending_q & ~swap_done_q) | swap_req;
    swap_done_d = pending_d & ((state_d == ST_FRAME_END) | (state_d == ST_IDLE));
    front_sel_d = front_sel_q ^ swap_done_q;
    wr_ready_d  = ~swap_done_d;
  end

  // Host write handshake and out-of-range detection.
  always_comb begin
    wr_acc_s = wr_valid & wr_ready;
    wr_in_s  = (wr_addr < DEPTH_A);
    wr_we_s  = wr_acc_s & wr_in_s;
    wr_err_d = wr_acc_s & ~wr_in_s;
  end

  // Buffer ports: front gets reads only, back gets writes only.
  always_comb begin
    rd_en_s = (state_q == ST_SCAN);
    b0_re   = rd_en_s & ~front_sel_q;
    b1_re   = rd_en_s & front_sel_q;
    b0_we   = wr_we_s & front_sel_q;
    b1_we   = wr_we_s & ~front_sel_q;
    if (b0_re) begin
      b0_addr = addr_q;
    end else if (b0_we) begin
      b0_addr = wr_addr;
    end else begin
      b0_addr = ADDR_ZERO;
    end
    if (b1_re) begin
      b1_addr = addr_q;
    end else if (b1_we) begin
      b1_addr = wr_addr;
    end else begin
      b1_addr = ADDR_ZERO;
    end
    if (b0_we) begin
      b0_wdata = wr_data;
    end else begin
      b0_wdata = 32'd0;
    end
    if (b1_we) begin
      b1_wdata = wr_data;
    end else begin
      b1_wdata = 32'd0;
    end
  end

  // Pixel sideband follows the read by one cycle to line up with the RAM data.
  always_comb begin
    pix_valid_d = rd_en_s;
    pix_sel_d   = front_sel_q;
    if (rd_en_s) begin
      pix_x_d   = x_q;
      pix_y_d   = y_q;
      pix_sof_d = (addr_q == ADDR_ZERO);
      pix_eol_d = (x_q == X_LAST);
    end else begin
      pix_x_d   = 16'd0;
      pix_y_d   = 16'd0;
      pix_sof_d = 1'b0;
      pix_eol_d = 1'b0;
    end
  end

  // State register for the sequencer, swap control, write status and pixel pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= ADDR_ZERO;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      front_sel_q <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_sel_q   <= 1'b0;
      pix_x_q     <= 16'd0;
      pix_y_q     <= 16'd0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
      wr_ready_q  <= wr_ready_d;
      wr_err_q    <= wr_err_d;
      pix_valid_q <= pix_valid_d;
      pix_sel_q   <= pix_sel_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_sof_q   <= pix_sof_d;
      pix_eol_q   <= pix_eol_d;
    end
  end

  // Scan-out data comes straight from the registered RAM outputs of the
  // buffer that was front when the read was issued.
  always_comb begin
    if (pix_valid_q) begin
      if (pix_sel_q) begin
        pix_r = b1_r;
        pix_g = b1_g;
        pix_b = b1_b;
      end else begin
        pix_r = b0_r;
        pix_g = b0_g;
        pix_b = b0_b;
      end
    end else begin
      pix_r = 8'd0;
      pix_g = 8'd0;
      pix_b = 8'd0;
    end
  end

  assign swap_done = swap_done_q;
  assign front_sel = front_sel_q;
  // Gating with reset keeps writes blocked from the first reset cycle on.
  assign wr_ready  = wr_ready_q & ~reset;
  assign wr_err    = wr_err_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_sof   = pix_sof_q;
  assign pix_eol   = pix_eol_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl with a behavioural two-buffer RAM model.
module tb_frame_buf_ctrl;

  localparam int DEPTH = 10000;

  logic        clk = 1'b0;
  logic        reset, scan_en, swap_req, wr_valid;
  logic [19:0] wr_addr;
  logic [31:0] wr_data;
  logic        swap_done, front_sel, wr_ready, wr_err;
  logic        b0_re, b0_we, b1_re, b1_we;
  logic [19:0] b0_addr, b1_addr;
  logic [31:0] b0_wdata, b1_wdata;
  logic [7:0]  b0_r, b0_g, b0_b, b1_r, b1_g, b1_b;
  logic        pix_valid, pix_sof, pix_eol;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [15:0] pix_x, pix_y;

  int   n_cmp = 0;
  int   n_err = 0;
  int   excl_bad = 0;
  int   swaps = 0;
  logic preload = 1'b0;

  logic [23:0] mem0 [0:DEPTH-1];
  logic [23:0] mem1 [0:DEPTH-1];
  logic [23:0] rd0_q, rd1_q;

  frame_buf_ctrl dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .swap_req(swap_req),
    .swap_done(swap_done), .front_sel(front_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err),
    .b0_re(b0_re), .b0_we(b0_we), .b0_addr(b0_addr), .b0_wdata(b0_wdata),
    .b0_r(b0_r), .b0_g(b0_g), .b0_b(b0_b),
    .b1_re(b1_re), .b1_we(b1_we), .b1_addr(b1_addr), .b1_wdata(b1_wdata),
    .b1_r(b1_r), .b1_g(b1_g), .b1_b(b1_b),
    .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  always #5 clk = ~clk;

  // Initial content of buffer 0; word 5 carries the known test pixel.
  function automatic logic [23:0] pat0(input int a);
    logic [7:0] b, g, r;
    if (a == 5) return 24'h332211;
    b = 8'(a) ^ 8'h3C;
    g = 8'(a >> 8);
    r = 8'(a);
    return {b, g, r};
  endfunction

  // Host write data for the back buffer; top byte must be ignored.
  function automatic logic [31:0] pat1(input int a);
    logic [7:0] b, g, r;
    b = 8'(a * 7);
    g = 8'(a >> 4);
    r = 8'(a) ^ 8'hF0;
    return {8'hA5, b, g, r};
  endfunction

  // RAM model: one-cycle registered read, write on the clock edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem0[i] <= pat0(i);
        mem1[i] <= ~pat0(i);
      end
    end else begin
      if (b0_we && b0_addr < 20'd10000) mem0[b0_addr] <= b0_wdata[23:0];
      if (b1_we && b1_addr < 20'd10000) mem1[b1_addr] <= b1_wdata[23:0];
    end
    if (b0_re && b0_addr < 20'd10000) rd0_q <= mem0[b0_addr];
    if (b1_re && b1_addr < 20'd10000) rd1_q <= mem1[b1_addr];
  end

  assign b0_r = rd0_q[7:0];
  assign b0_g = rd0_q[15:8];
  assign b0_b = rd0_q[23:16];
  assign b1_r = rd1_q[7:0];
  assign b1_g = rd1_q[15:8];
  assign b1_b = rd1_q[23:16];

  // Mid-cycle tallies: read/write collisions on one buffer and swap pulses.
  always @(negedge clk) begin
    if ((b0_re && b0_we) || (b1_re && b1_we)) excl_bad <= excl_bad + 1;
    if (swap_done) swaps <= swaps + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix_match(input int a, input logic [23:0] exp, output bit ok);
    ok = (pix_valid === 1'b1) && (pix_x === 16'(a % 100)) && (pix_y === 16'(a / 100)) &&
         (pix_sof === (a == 0)) && (pix_eol === ((a % 100) == 99)) &&
         ({pix_b, pix_g, pix_r} === exp);
  endtask

  initial begin
    bit          ok;
    int          bad, wbad, s0;
    logic [31:0] wd;
    logic [23:0] ex;

    reset = 1'b1; scan_en = 1'b0; swap_req = 1'b0; wr_valid = 1'b0;
    wr_addr = 20'd0; wr_data = 32'd0; preload = 1'b1;
    tick(); preload = 1'b0;
    tick(); tick();
    chk("rst_front_sel", 32'(front_sel), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_re", 32'({b0_re, b1_re}), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);

    // Frame 0 from buffer 0: release reset with scan enabled.
    reset = 1'b0; scan_en = 1'b1;
    tick();
    chk("c1_b0_re", 32'(b0_re), 32'd1);
    chk("c1_b0_addr", 32'(b0_addr), 32'd0);
    chk("c1_b1_re", 32'(b1_re), 32'd0);
    chk("c1_pix_valid", 32'(pix_valid), 32'd0);
    chk("c1_wr_ready", 32'(wr_ready), 32'd1);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      tick();
      pix_match(a, pat0(a), ok);
      if (!ok) bad++;
      if (a == 0) begin
        chk("f0_sof", 32'(pix_sof), 32'd1);
        chk("f0_xy0", 32'({pix_x, pix_y}), 32'd0);
      end
      if (a == 5) begin
        chk("f0_p5_r", 32'(pix_r), 32'h11);
        chk("f0_p5_g", 32'(pix_g), 32'h22);
        chk("f0_p5_b", 32'(pix_b), 32'h33);
      end
      if (a == 99) begin
        chk("f0_eol99", 32'(pix_eol), 32'd1);
        chk("f0_x99", 32'(pix_x), 32'd99);
      end
      if (a == 100) chk("f0_y1", 32'({pix_x, pix_y}), 32'h0000_0001);
      if (a == DEPTH - 1) begin
        chk("f0_last_xy", 32'({pix_x, pix_y}), 32'h0063_0063);
        chk("f0_last_eol", 32'(pix_eol), 32'd1);
        chk("f0_fe_no_re", 32'({b0_re, b1_re}), 32'd0);
      end
    end
    chk("f0_pixels_bad", 32'(bad), 32'd0);

    tick();
    chk("bubble_pix_valid", 32'(pix_valid), 32'd0);
    chk("f1_b0_re", 32'(b0_re), 32'd1);
    chk("f1_b0_addr", 32'(b0_addr), 32'd0);

    // Frame 1: stream host writes 0..9999 into buffer 1, two swap requests.
    s0 = swaps; bad = 0; wbad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k > 0) begin
        tick();
        pix_match(k - 1, pat0(k - 1), ok);
        if (!ok || front_sel !== 1'b0) bad++;
      end
      wr_valid = 1'b1; wr_addr = 20'(k); wr_data = pat1(k);
      swap_req = (k == 2000) || (k == 5000);
      #1;
      if (!(b1_we === 1'b1 && b0_we === 1'b0 && b1_addr === 20'(k) &&
            b1_wdata === pat1(k) && wr_ready === 1'b1)) wbad++;
    end
    tick();
    pix_match(DEPTH - 1, pat0(DEPTH - 1), ok);
    chk("f1_last_pixel", 32'(ok), 32'd1);
    chk("fe_swap_done", 32'(swap_done), 32'd1);
    chk("fe_wr_ready", 32'(wr_ready), 32'd0);
    chk("fe_front_old", 32'(front_sel), 32'd0);
    chk("fe_no_re", 32'({b0_re, b1_re}), 32'd0);
    wr_valid = 1'b0; swap_req = 1'b0;
    chk("f1_pixels_bad", 32'(bad), 32'd0);
    chk("f1_writes_bad", 32'(wbad), 32'd0);

    tick();
    chk("f2_front_sel", 32'(front_sel), 32'd1);
    chk("f2_swap_done", 32'(swap_done), 32'd0);
    chk("f2_wr_ready", 32'(wr_ready), 32'd1);
    chk("f2_re", 32'({b0_re, b1_re}), 32'd1);
    chk("f2_b1_addr", 32'(b1_addr), 32'd0);
    chk("f2_bubble", 32'(pix_valid), 32'd0);
    chk("f1_one_swap", 32'(swaps - s0), 32'd1);

    // Frame 2 from buffer 1; out-of-range write, then reset at a=5000.
    s0 = swaps; bad = 0;
    for (int a = 0; a < 5000; a++) begin
      tick();
      wd = pat1(a);
      pix_match(a, wd[23:0], ok);
      if (!ok) bad++;
      if (a == 10) begin
        wr_valid = 1'b1; wr_addr = 20'd10000; wr_data = 32'h00FF_FFFF;
        #1;
        chk("oor_we", 32'({b0_we, b1_we}), 32'd0);
        chk("oor_ready", 32'(wr_ready), 32'd1);
      end
      if (a == 11) begin
        chk("oor_err", 32'(wr_err), 32'd1);
        wr_valid = 1'b1; wr_addr = 20'd7; wr_data = 32'h77C1_B2A3;
        #1;
        chk("b0_back_we", 32'({b0_we, b1_we}), 32'h2);
        chk("b0_back_addr", 32'(b0_addr), 32'd7);
        chk("b0_back_wdata", b0_wdata, 32'h77C1_B2A3);
      end
      if (a == 12) begin
        chk("err_one_cycle", 32'(wr_err), 32'd0);
        wr_valid = 1'b0;
      end
      if (a == 4999) begin
        chk("a5000_b1_re", 32'(b1_re), 32'd1);
        chk("a5000_b1_addr", 32'(b1_addr), 32'd5000);
        reset = 1'b1;
      end
    end
    chk("f2_pixels_bad", 32'(bad), 32'd0);

    tick();
    chk("midrst_front_sel", 32'(front_sel), 32'd0);
    chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
    chk("midrst_re", 32'({b0_re, b1_re}), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
    chk("midrst_flags", 32'({swap_done, wr_err, pix_sof, pix_eol}), 32'd0);
    chk("midrst_xy", 32'({pix_x, pix_y}), 32'd0);
    chk("midrst_rgb", 32'({pix_r, pix_g, pix_b}), 32'd0);
    chk("midrst_b1_addr", 32'(b1_addr), 32'd0);
    chk("double_req_single_swap", 32'(swaps - s0), 32'd0);

    tick();
    reset = 1'b0;
    tick();
    chk("rs_b0_re", 32'(b0_re), 32'd1);
    chk("rs_b0_addr", 32'(b0_addr), 32'd0);
    chk("rs_front_sel", 32'(front_sel), 32'd0);
    for (int a = 0; a < 8; a++) begin
      tick();
      ex = (a == 7) ? 24'hC1B2A3 : pat0(a);
      pix_match(a, ex, ok);
      chk($sformatf("rs_pix%0d", a), 32'(ok), 32'd1);
    end
    chk("exclusivity", 32'(excl_bad), 32'd0);

    // Swaps while idle, including a request in the toggle cycle itself.
    reset = 1'b1; scan_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_no_re", 32'({b0_re, b1_re}), 32'd0);
    chk("idle_front", 32'(front_sel), 32'd0);
    chk("idle_ready", 32'(wr_ready), 32'd1);
    swap_req = 1'b1;
    tick();
    chk("idle_sw1_done", 32'(swap_done), 32'd1);
    chk("idle_sw1_ready", 32'(wr_ready), 32'd0);
    chk("idle_sw1_front", 32'(front_sel), 32'd0);
    tick();
    chk("idle_sw2_done", 32'(swap_done), 32'd1);
    chk("idle_sw2_front", 32'(front_sel), 32'd1);
    swap_req = 1'b0;
    tick();
    chk("idle_after_done", 32'(swap_done), 32'd0);
    chk("idle_after_front", 32'(front_sel), 32'd0);
    chk("idle_after_ready", 32'(wr_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
